md5_wr_stream: RTL and testbench
================================

# md5_wr_stream

AXI4 write-master stream engine: drains a 512-bit valid/ready stream into host memory as INCR bursts on the AW/W/B channels. Companion to the MD5 input-read path, sharing its softreg map style and credit scheme, so accelerator results or pass-through data can be written back. Software programs base address, credit limit and beat count, then polls progress and status over softreg.

## Interface
Parameters:
- AWID, 0: constant value driven on awid_m.
- LQ_LOG_DEPTH, 4: log2 depth of the burst-length queue; credits written must be ≤ 2^LQ_LOG_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream beat valid
- in_data  in  512  stream beat
- in_ready  out  1  stream beat accepted when in_valid && in_ready
- awid_m/awaddr_m/awlen_m/awsize_m  out  16/64/8/3  AW payload
- awvalid_m / awready_m  out/in  1  AW handshake
- wdata_m/wstrb_m/wlast_m  out  512/64/1  W payload
- wvalid_m / wready_m  out/in  1  W handshake
- bid_m/bresp_m  in  16/2  B payload
- bvalid_m / bready_m  in/out  1  B handshake
- softreg_req_valid, softreg_req_isWrite  in  1  request strobe, write flag
- softreg_req_addr / softreg_req_data  in  32/64  request address, data
- softreg_resp_valid / softreg_resp_data  out  1/64  read response

## Operation
- Softreg writes: 0x10 addr (byte address, 64B aligned); 0x18 credits (max outstanding bursts); 0x20 words (beats to write) — also clears beats_sent, outstanding count and error bit.
- Softreg reads: 0x28 beats_sent (W handshakes); 0x30 status {62'b0, err, busy}; other addresses: resp_data unchanged.
- Burst length: len = min(words, 64 − addr[11:6]) — never crosses 4 KB, max 64 beats. awlen_m = len−1, awsize_m = 3'b110, awid_m = AWID, awaddr_m = addr.
- awvalid_m = (words≠0) && (credits≠0) && !lq_full. On AW handshake: addr += len<<6, words −= len, len pushed to length queue.
- Credits: −1 on AW handshake, +1 on B handshake, unchanged when both occur in the same cycle.
- W path: active only while length queue non-empty. wvalid_m = in_valid && lq_nonempty; in_ready = wready_m && lq_nonempty; wdata_m = in_data; wstrb_m = all ones; wlast_m when beat counter = head len − 1. On the last-beat handshake: head is popped and beat counter reset to 0.
- W beats never precede their AW handshake.
- bready_m tied 1. outstanding +1 on AW handshake, −1 on B handshake.
- busy = words≠0 || lq_nonempty || outstanding≠0.
- A softreg write in the same cycle as a handshake update of the same register wins.

## Timing
- Reset values: awvalid_m, wvalid_m, in_ready, wlast_m = 0; softreg_resp_valid = 0, softreg_resp_data = 0; addr = 0, words = 0, credits = 8, length queue empty, beat counter 0, err 0.
- AW/W outputs are combinational from registered state and stream inputs. First awvalid_m one cycle after the 0x20 write.
- First wvalid_m is possible in the cycle after the AW handshake (length-queue write latency 1).
- Softreg read response: exactly 1 cycle after the request; resp_valid only for reads.
- Full throughput: 1 W beat per cycle when wready_m and in_valid are held high.
- Reset mid-operation: all state cleared next edge and outstanding bursts abandoned. Software must quiesce (busy = 0) before asserting rst.
- words = 0 written: no AW is issued and busy falls once outstanding bursts drain.

## Configuration
- WR_BRESP_CHECK_EN defined: a B handshake with bresp_m≠0 sets sticky status bit 1 (err), cleared by a 0x20 write or reset.
- WR_BRESP_CHECK_EN undefined: bresp_m is ignored and status bit 1 reads 0.

## Test plan
- Single burst: addr 0x1000, credits 8, words 4, stream always valid, ready always 1 -> one AW (awaddr 0x1000, awlen 3); 4 W beats with wlast on beat 4; beats_sent 4; busy 0 after B.
- 4 KB split: addr 0x1F80, words 10 -> AW awlen 1 at 0x1F80, then AW awlen 7 at 0x2000; wlast on beats 2 and 10.
- Credit stall: credits 1, words 128, B withheld 20 cycles -> exactly one AW outstanding; second AW only after the B handshake; same-cycle AW+B leaves credits unchanged.
- Backpressure: random wready_m/in_valid at 50% -> no beat dropped or duplicated; data order preserved; beats_sent 128.
- Error response (macro on): bresp 2'b10 on burst 2 -> status reads 0x3 while busy; after a 0x20 write err is cleared. Macro off: status bit 1 stays 0.
- Softreg: read 0x28 -> resp_valid exactly 1 cycle later; write requests produce no resp_valid; reset mid-burst -> awvalid_m/wvalid_m 0 on the next cycle, credits 8.

Source files
------------

// File: rtl/md5_wr_stream.sv
// AXI4 write-master stream engine: drains a 512-bit stream into host memory as INCR bursts.
// Optional WR_BRESP_CHECK_EN: non-OKAY write responses set a sticky error bit in status.
module md5_wr_stream #(
   parameter logic [15:0] AWID         = 16'd0,
   parameter int          LQ_LOG_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [511:0] in_data,
   output logic         in_ready,
   output logic [15:0]  awid_m,
   output logic [63:0]  awaddr_m,
   output logic [7:0]   awlen_m,
   output logic [2:0]   awsize_m,
   output logic         awvalid_m,
   input  logic         awready_m,
   output logic [511:0] wdata_m,
   output logic [63:0]  wstrb_m,
   output logic         wlast_m,
   output logic         wvalid_m,
   input  logic         wready_m,
   input  logic [15:0]  bid_m,
   input  logic [1:0]   bresp_m,
   input  logic         bvalid_m,
   output logic         bready_m,
   input  logic         softreg_req_valid,
   input  logic         softreg_req_isWrite,
   input  logic [31:0]  softreg_req_addr,
   input  logic [63:0]  softreg_req_data,
   output logic         softreg_resp_valid,
   output logic [63:0]  softreg_resp_data
);

   localparam int LQ_DEPTH = 1 << LQ_LOG_DEPTH;
   localparam logic [LQ_LOG_DEPTH:0] LQ_FULL_CNT = (LQ_LOG_DEPTH+1)'(LQ_DEPTH);

   logic [63:0]             addr_q;
   logic [63:0]             words_q;
   logic [63:0]             beats_sent_q;
   logic [15:0]             credits_q;
   logic [15:0]             outstanding_q;
   logic [6:0]              lq_mem [LQ_DEPTH];
   logic [LQ_LOG_DEPTH-1:0] lq_wr_ptr;
   logic [LQ_LOG_DEPTH-1:0] lq_rd_ptr;
   logic [LQ_LOG_DEPTH:0]   lq_cnt;
   logic [5:0]              beat_cnt;
   logic                    err_q;

   logic       lq_nonempty, lq_full;
   logic [6:0] room, len, lq_head;
   logic       aw_hs, w_hs, w_last_hs, b_hs, busy;
   logic       wr_addr, wr_credits, wr_words, rd_req;
   logic       unused_inputs;

   assign unused_inputs = ^{bid_m, bresp_m, softreg_req_data[63:16]};

   assign lq_nonempty = (lq_cnt != '0);
   assign lq_full     = (lq_cnt == LQ_FULL_CNT);
   assign lq_head     = lq_mem[lq_rd_ptr];

   // Beats left before the next 4 KB boundary caps the burst length.
   assign room = 7'd64 - {1'b0, addr_q[11:6]};
   assign len  = (words_q < {57'd0, room}) ? words_q[6:0] : room;

   assign awid_m    = AWID;
   assign awaddr_m  = addr_q;
   assign awlen_m   = {1'b0, len - 7'd1};
   assign awsize_m  = 3'b110;
   assign awvalid_m = (words_q != 64'd0) && (credits_q != 16'd0) && !lq_full;

   assign wvalid_m  = in_valid && lq_nonempty;
   assign in_ready  = wready_m && lq_nonempty;
   assign wdata_m   = in_data;
   assign wstrb_m   = '1;
   assign wlast_m   = lq_nonempty && ({1'b0, beat_cnt} == lq_head - 7'd1);
   assign bready_m  = 1'b1;

   assign aw_hs     = awvalid_m && awready_m;
   assign w_hs      = wvalid_m && wready_m;
   assign w_last_hs = w_hs && wlast_m;
   assign b_hs      = bvalid_m && bready_m;
   assign busy      = (words_q != 64'd0) || lq_nonempty || (outstanding_q != 16'd0);

   assign wr_addr    = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == 32'h10);
   assign wr_credits = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == 32'h18);
   assign wr_words   = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == 32'h20);
   assign rd_req     = softreg_req_valid && !softreg_req_isWrite;

   always_ff @(posedge clk) begin
      if (aw_hs) lq_mem[lq_wr_ptr] <= len;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q             <= '0;
         words_q            <= '0;
         beats_sent_q       <= '0;
         credits_q          <= 16'd8;
         outstanding_q      <= '0;
         lq_wr_ptr          <= '0;
         lq_rd_ptr          <= '0;
         lq_cnt             <= '0;
         beat_cnt           <= '0;
         softreg_resp_valid <= 1'b0;
         softreg_resp_data  <= '0;
      end else begin
         // Software writes take priority over handshake-driven updates.
         if (wr_addr)    addr_q <= softreg_req_data;
         else if (aw_hs) addr_q <= addr_q + {51'd0, len, 6'd0};

         if (wr_words)   words_q <= softreg_req_data;
         else if (aw_hs) words_q <= words_q - {57'd0, len};

         if (wr_credits)          credits_q <= softreg_req_data[15:0];
         else if (aw_hs && !b_hs) credits_q <= credits_q - 16'd1;
         else if (b_hs && !aw_hs) credits_q <= credits_q + 16'd1;

         if (wr_words)            outstanding_q <= '0;
         else if (aw_hs && !b_hs) outstanding_q <= outstanding_q + 16'd1;
         else if (b_hs && !aw_hs) outstanding_q <= outstanding_q - 16'd1;

         if (wr_words)  beats_sent_q <= '0;
         else if (w_hs) beats_sent_q <= beats_sent_q + 64'd1;

         if (aw_hs)     lq_wr_ptr <= lq_wr_ptr + 1'b1;
         if (w_last_hs) lq_rd_ptr <= lq_rd_ptr + 1'b1;
         if (aw_hs && !w_last_hs)      lq_cnt <= lq_cnt + 1'b1;
         else if (w_last_hs && !aw_hs) lq_cnt <= lq_cnt - 1'b1;

         if (w_last_hs) beat_cnt <= '0;
         else if (w_hs) beat_cnt <= beat_cnt + 6'd1;

         softreg_resp_valid <= rd_req;
         if (rd_req) begin
            if (softreg_req_addr == 32'h28)      softreg_resp_data <= beats_sent_q;
            else if (softreg_req_addr == 32'h30) softreg_resp_data <= {62'd0, err_q, busy};
         end
      end
   end

`ifdef WR_BRESP_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                            err_q <= 1'b0;
      else if (wr_words)                  err_q <= 1'b0;
      else if (b_hs && bresp_m != 2'b00)  err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_md5_wr_stream.sv
// Randomized self-checking bench for md5_wr_stream against a burst-splitting reference model.
module tb_md5_wr_stream;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [511:0] in_data;
   logic         in_ready;
   logic [15:0]  awid_m;
   logic [63:0]  awaddr_m;
   logic [7:0]   awlen_m;
   logic [2:0]   awsize_m;
   logic         awvalid_m, awready_m;
   logic [511:0] wdata_m;
   logic [63:0]  wstrb_m;
   logic         wlast_m, wvalid_m, wready_m;
   logic [15:0]  bid_m;
   logic [1:0]   bresp_m;
   logic         bvalid_m, bready_m;
   logic         softreg_req_valid, softreg_req_isWrite;
   logic [31:0]  softreg_req_addr;
   logic [63:0]  softreg_req_data;
   logic         softreg_resp_valid;
   logic [63:0]  softreg_resp_data;

   always #5 clk = ~clk;

   md5_wr_stream #(.AWID(16'h0005), .LQ_LOG_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
      .awvalid_m(awvalid_m), .awready_m(awready_m),
      .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
      .wvalid_m(wvalid_m), .wready_m(wready_m),
      .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
      .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
      .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
      .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
   );

`ifdef WR_BRESP_CHECK_EN
   localparam logic [63:0] ERR_BIT = 64'd2;
`else
   localparam logic [63:0] ERR_BIT = 64'd0;
`endif

   typedef struct {
      logic [63:0] a;
      int          len;
   } aw_t;

   int errors = 0;
   int checks = 0;

   aw_t exp_aw[$];
   int  m_lens[$];
   int  b_pending[$];
   int  m_beat = 0, m_out = 0, cfg_credits = 8;
   int  src_idx = 0, w_idx = 0, w_target = 0, aw_cnt = 0, b_cnt = 0;
   int  err_at = -1;
   int  v_rate = 100, w_rate = 100, a_rate = 100;
   bit  b_block = 1'b0;
   bit  prev_read = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] gen(input int unsigned k);
      logic [31:0] w;
      w = (k * 32'h9E37_79B1) ^ 32'h5A3C_0000 ^ k;
      return {16{w}};
   endfunction

   // Stream source and AW/W ready generators.
   initial begin
      in_valid = 1'b0; in_data = '0; wready_m = 1'b0; awready_m = 1'b0;
      forever begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(99) < v_rate);
         in_data   = gen(src_idx);
         wready_m  = ($urandom_range(99) < w_rate);
         awready_m = ($urandom_range(99) < a_rate);
      end
   end

   // Write-response slave: one B per completed burst, in order.
   initial begin
      bvalid_m = 1'b0; bresp_m = 2'b00; bid_m = 16'h0005;
      forever begin
         @(posedge clk); #1;
         if (bvalid_m && b_pending.size() > 0) b_pending.delete(0);
         if (!b_block && b_pending.size() > 0 && $urandom_range(3) != 0) begin
            bvalid_m = 1'b1;
            bresp_m  = (b_cnt == err_at) ? 2'b10 : 2'b00;
         end else begin
            bvalid_m = 1'b0;
            bresp_m  = 2'b00;
         end
      end
   end

   // Monitor: samples mid-cycle what the next rising edge will commit.
   always @(negedge clk) begin
      if (rst) begin
         prev_read = 1'b0;
      end else begin
         chk("resp_valid", 64'(softreg_resp_valid), 64'(prev_read));
         prev_read = softreg_req_valid && !softreg_req_isWrite;
         chk("bready", 64'(bready_m), 64'd1);
         if (in_valid && in_ready) src_idx++;
         if (wvalid_m && wready_m) begin
            if (m_lens.size() == 0) begin
               chk("w_before_aw", 64'd1, 64'd0);
            end else begin
               logic [511:0] ed;
               bit exp_last;
               ed = gen(w_idx);
               chk("wdata", 64'(wdata_m == ed), 64'd1);
               chk("wstrb", wstrb_m, {64{1'b1}});
               exp_last = (m_beat == m_lens[0] - 1);
               chk("wlast", 64'(wlast_m), 64'(exp_last));
               if (exp_last) begin
                  m_lens.delete(0);
                  m_beat = 0;
                  b_pending.push_back(1);
               end else begin
                  m_beat++;
               end
            end
            w_idx++;
         end
         if (awvalid_m && awready_m) begin
            aw_cnt++;
            if (exp_aw.size() == 0) begin
               chk("aw_unexpected", 64'd1, 64'd0);
            end else begin
               aw_t e;
               e = exp_aw.pop_front();
               chk("awaddr", awaddr_m, e.a);
               chk("awlen", 64'(awlen_m), 64'(e.len - 1));
               chk("awsize", 64'(awsize_m), 64'd6);
               chk("awid", 64'(awid_m), 64'h5);
               chk("credit_limit", 64'(m_out < cfg_credits), 64'd1);
               m_lens.push_back(e.len);
               m_out++;
            end
         end
         if (bvalid_m && bready_m) begin
            b_cnt++;
            m_out--;
         end
      end
   end

   task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
      @(posedge clk); #1;
      softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b1;
      softreg_req_addr = a; softreg_req_data = d;
      @(posedge clk); #1;
      softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
   endtask

   task automatic sr_read(input logic [31:0] a, output logic [63:0] d);
      @(posedge clk); #1;
      softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b0; softreg_req_addr = a;
      @(posedge clk); #1;
      softreg_req_valid = 1'b0;
      d = softreg_resp_data;
   endtask

   // Reference split: bursts of at most 64 beats that never cross 4 KB.
   task automatic start_xfer(input logic [63:0] a, input logic [63:0] w, input int cr);
      logic [63:0] aa, ww;
      int room, len;
      if (cr > 0) begin
         sr_write(32'h18, 64'(cr));
         cfg_credits = cr;
      end
      sr_write(32'h10, a);
      aa = a; ww = w;
      while (ww != 0) begin
         room = 64 - int'((aa % 4096) / 64);
         len  = (ww < 64'(room)) ? int'(ww) : room;
         exp_aw.push_back('{aa, len});
         aa = aa + 64'(len) * 64;
         ww = ww - 64'(len);
      end
      w_target = w_idx + int'(w);
      sr_write(32'h20, w);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!(exp_aw.size() == 0 && m_lens.size() == 0 && b_pending.size() == 0 &&
               m_out == 0 && w_idx == w_target) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_done"}, 64'(n < budget), 64'd1);
   endtask

   task automatic finish_xfer(input string tag, input logic [63:0] words);
      logic [63:0] d;
      wait_done(tag, 6000);
      sr_read(32'h28, d);
      chk({tag, "_beats"}, d, words);
      sr_read(32'h30, d);
      chk({tag, "_status"}, d, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] d;
      int aw0, n;
      rst = 1'b1;
      softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
      softreg_req_addr = '0; softreg_req_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_awvalid", 64'(awvalid_m), 64'd0);
      chk("rst_wvalid", 64'(wvalid_m), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wlast", 64'(wlast_m), 64'd0);
      chk("rst_resp_valid", 64'(softreg_resp_valid), 64'd0);
      chk("rst_resp_data", softreg_resp_data, 64'd0);
      sr_read(32'h30, d); chk("rst_status", d, 64'd0);
      sr_read(32'h28, d); chk("rst_beats", d, 64'd0);

      // Single burst
      aw0 = aw_cnt;
      start_xfer(64'h1000, 64'd4, 8);
      finish_xfer("single", 64'd4);
      chk("single_aw_count", 64'(aw_cnt - aw0), 64'd1);

      // 4 KB boundary split
      aw0 = aw_cnt;
      start_xfer(64'h1F80, 64'd10, 0);
      finish_xfer("split", 64'd10);
      chk("split_aw_count", 64'(aw_cnt - aw0), 64'd2);

      // Credit stall: one credit, B withheld
      aw0 = aw_cnt;
      b_block = 1'b1;
      start_xfer(64'h0, 64'd128, 1);
      repeat (64 + 40) @(posedge clk);
      @(negedge clk);
      chk("stall_aw_count", 64'(aw_cnt - aw0), 64'd1);
      chk("stall_awvalid", 64'(awvalid_m), 64'd0);
      b_block = 1'b0;
      finish_xfer("stall", 64'd128);
      chk("stall_aw_total", 64'(aw_cnt - aw0), 64'd2);

      // Two credits, back-to-back bursts so AW and B coincide
      start_xfer(64'h20000, 64'd320, 2);
      finish_xfer("cred2", 64'd320);

      // Backpressure at 50%
      v_rate = 50; w_rate = 50; a_rate = 50;
      start_xfer(64'h40040, 64'd128, 4);
      finish_xfer("bp", 64'd128);
      for (int i = 0; i < 3; i++) begin
         logic [63:0] ra, rw;
         ra = {48'd0, 10'($urandom_range(0, 1023)), 6'd0};
         rw = 64'($urandom_range(1, 200));
         v_rate = $urandom_range(30, 100); w_rate = $urandom_range(30, 100);
         a_rate = $urandom_range(30, 100);
         start_xfer(ra, rw, $urandom_range(1, 16));
         finish_xfer("rand", rw);
      end
      v_rate = 100; w_rate = 100; a_rate = 100;

      // Error response on the second burst
      err_at = b_cnt + 1;
      start_xfer(64'h0, 64'd256, 8);
      n = 0;
      while (b_cnt < err_at + 1 && n < 2000) begin @(posedge clk); n++; end
      chk("err_b_seen", 64'(n < 2000), 64'd1);
      sr_read(32'h30, d); chk("err_status_busy", d, ERR_BIT | 64'd1);
      wait_done("err", 6000);
      sr_read(32'h30, d); chk("err_status_idle", d, ERR_BIT);
      err_at = -1;
      sr_write(32'h20, 64'd0);
      sr_read(32'h30, d); chk("err_cleared", d, 64'd0);
      repeat (20) @(posedge clk);
      sr_read(32'h30, d); chk("zero_words_idle", d, 64'd0);

      // Reset mid-burst
      start_xfer(64'h8000, 64'd256, 8);
      repeat (40) @(posedge clk);
      #1 b_block = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      exp_aw.delete(); m_lens.delete(); b_pending.delete();
      m_out = 0; m_beat = 0; cfg_credits = 8; w_target = w_idx;
      b_block = 1'b0;
      @(negedge clk);
      chk("mid_rst_awvalid", 64'(awvalid_m), 64'd0);
      chk("mid_rst_wvalid", 64'(wvalid_m), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      sr_read(32'h30, d); chk("mid_rst_status", d, 64'd0);
      sr_read(32'h28, d); chk("mid_rst_beats", d, 64'd0);

      // Credits back at 8 after reset: eight bursts then stall
      aw0 = aw_cnt;
      b_block = 1'b1;
      start_xfer(64'h0, 64'd640, 0);
      repeat (8 * 64 + 80) @(posedge clk);
      @(negedge clk);
      chk("dflt_cred_aw_count", 64'(aw_cnt - aw0), 64'd8);
      chk("dflt_cred_awvalid", 64'(awvalid_m), 64'd0);
      b_block = 1'b0;
      finish_xfer("dflt_cred", 64'd640);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
